// File: rtl/bitcoin_pkg.sv
// Shared definitions for the bitcoin hash engine: checker FSM states, the
// difficulty ceiling and the SHA-256 round/IV constants used by the hasher.
package bitcoin_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_FLUSH,
    ST_WB,
    ST_FIN
  } state_t;

  localparam logic [31:0] MAX_TARGET = 32'hFFFFFFFF;

  localparam logic [31:0] SHA256_K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] SHA256_H_INIT [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] sha256_k(input logic [5:0] i);
    return SHA256_K[i];
  endfunction

  function automatic logic [31:0] sha256_h_init(input logic [2:0] i);
    return SHA256_H_INIT[i];
  endfunction

endpackage

// File: rtl/bitcoin_nonce_checker_nonce_cmp_acc.sv
// Per-word evaluation against the target plus the found/winner/count/minimum
// accumulators. clr restarts a scan; vld marks a word to evaluate.
module nonce_cmp_acc
  import bitcoin_pkg::*;
#(
  parameter int NW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          vld,
  input  logic [31:0]   word,
  input  logic [NW-1:0] idx,
  input  logic [31:0]   target,
  output logic          found,
  output logic [NW-1:0] win_nonce,
  output logic [NW:0]   win_count,
  output logic [31:0]   min_hash,
  output logic [NW-1:0] min_nonce
);

  logic win;
  assign win = (word <= target);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      found     <= 1'b0;
      win_nonce <= '0;
      win_count <= '0;
      min_hash  <= MAX_TARGET;
      min_nonce <= '0;
    end else if (vld) begin
      if (win) begin
        win_count <= win_count + 1'b1;
        // only the first (lowest-index) winner is reported
        if (!found) begin
          found     <= 1'b1;
          win_nonce <= idx;
        end
      end
      // strict compare so equal minima keep the earlier index
      if (word < min_hash) begin
        min_hash  <= word;
        min_nonce <= idx;
      end
    end
  end

endmodule

// File: rtl/bitcoin_nonce_checker.sv
// Scans NUM_NONCE H0 words from memory and reports winners and minimum hash.
// Optional summary write-back: define BITCOIN_NONCE_CHECKER_RESULT_WB_EN.
module bitcoin_nonce_checker
  import bitcoin_pkg::*;
#(
  parameter  int NUM_NONCE = 16,
  localparam int NW        = $clog2(NUM_NONCE)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [15:0]   hash_addr,
  input  logic [15:0]   result_addr,
  input  logic [31:0]   target,
  output logic          busy,
  output logic          done,
  output logic          found,
  output logic [NW-1:0] win_nonce,
  output logic [NW:0]   win_count,
  output logic [31:0]   min_hash,
  output logic [NW-1:0] min_nonce,
  output logic          mem_clk,
  output logic          mem_we,
  output logic [15:0]   mem_addr,
  output logic [31:0]   mem_write_data,
  input  logic [31:0]   mem_read_data
);

  localparam int STAGES = 1;

  state_t          state;
  logic [NW-1:0]   rd_i;
  logic [NW-1:0]   cmp_i;
  logic [15:0]     hash_addr_q;
  logic [31:0]     target_q;
  logic [STAGES:0] vld_pipe;
  logic            clr;

  assign mem_clk     = clk;
  assign clr         = (state == ST_IDLE) && start;
  // stage 0 issues an address; stage 1 sees its data from the memory
  assign vld_pipe[0] = (state == ST_SCAN);

`ifdef BITCOIN_NONCE_CHECKER_RESULT_WB_EN
  logic [1:0] wb_i;
`else
  logic unused_result_addr;
  assign unused_result_addr = ^result_addr;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      rd_i        <= '0;
      cmp_i       <= '0;
      hash_addr_q <= '0;
      target_q    <= '0;
      vld_pipe[STAGES:1] <= '0;
`ifdef BITCOIN_NONCE_CHECKER_RESULT_WB_EN
      wb_i        <= '0;
`endif
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      cmp_i <= rd_i;
      done  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            target_q    <= target;
            hash_addr_q <= hash_addr;
            rd_i        <= '0;
            busy        <= 1'b1;
            state       <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          rd_i <= rd_i + 1'b1;
          if (rd_i == NW'(NUM_NONCE - 1)) state <= ST_FLUSH;
        end
        ST_FLUSH: begin
`ifdef BITCOIN_NONCE_CHECKER_RESULT_WB_EN
          wb_i  <= '0;
          state <= ST_WB;
`else
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_FIN;
`endif
        end
`ifdef BITCOIN_NONCE_CHECKER_RESULT_WB_EN
        ST_WB: begin
          wb_i <= wb_i + 1'b1;
          if (wb_i == 2'd2) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_FIN;
          end
        end
`endif
        ST_FIN:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_write_data = '0;
    case (state)
      ST_SCAN: mem_addr = hash_addr_q + 16'(rd_i);
`ifdef BITCOIN_NONCE_CHECKER_RESULT_WB_EN
      ST_WB: begin
        mem_we   = 1'b1;
        mem_addr = result_addr + 16'(wb_i);
        case (wb_i)
          2'd0:    mem_write_data = {found, 15'b0, 16'(win_count)};
          2'd1:    mem_write_data = 32'(win_nonce);
          default: mem_write_data = min_hash;
        endcase
      end
`endif
      default: ;
    endcase
  end

  nonce_cmp_acc #(.NW(NW)) u_acc (
    .clk       (clk),
    .reset     (reset),
    .clr       (clr),
    .vld       (vld_pipe[STAGES]),
    .word      (mem_read_data),
    .idx       (cmp_i),
    .target    (target_q),
    .found     (found),
    .win_nonce (win_nonce),
    .win_count (win_count),
    .min_hash  (min_hash),
    .min_nonce (min_nonce)
  );

endmodule
